// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the two-operand execute unit.
// Opcode encoding, condition-code bit positions and the sequencer state type.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_ILL = 3'd7
  } alu_op_t;

  // Condition-code register bit positions: {C,N,Z}
  localparam int CCR_C = 2;
  localparam int CCR_N = 1;
  localparam int CCR_Z = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_two_op_seq_if.sv
// alu_two_op_seq_if: issue/result handshake plus CCR restore path of the
// execute unit. master = operand-fetch/write-back side, slave = the unit.
interface alu_two_op_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) ();

  logic               in_valid;
  logic               in_ready;
  alu_op_t            in_op;
  logic [WIDTH-1:0]   in_rs;
  logic [WIDTH-1:0]   in_rd;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_illegal;
  logic [2:0]         ccr;
  logic               ccr_load;
  logic [2:0]         ccr_in;

  modport master (
    output in_valid, in_op, in_rs, in_rd, in_shamt, out_ready, ccr_load, ccr_in,
    input  in_ready, out_valid, out_data, out_illegal, ccr
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rd, in_shamt, out_ready, ccr_load, ccr_in,
    output in_ready, out_valid, out_data, out_illegal, ccr
  );

endinterface

// File: rtl/alu_shifter_iter.sv
// alu_shifter_iter: one-bit-per-cycle shifter for SHL (logical) and SHR
// (arithmetic). Amounts above WIDTH are clamped to WIDTH steps; a clamped
// SHL reports carry 0 because every original bit fell off before the end.
// done is high in the cycle whose closing edge performs the last step, and
// result/carry then show the value after that step so the caller can
// register it on the same edge.
module alu_shifter_iter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               left,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amount,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               carry
);

  localparam logic [SHAMT_W-1:0] WIDTH_SH = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] ONE_SH   = SHAMT_W'(1);

  logic [WIDTH-1:0]   work_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic               left_reg;
  logic               zero_c_reg;
  logic [WIDTH-1:0]   step_data;
  logic               step_c;

  // One shift step of the working register, capturing the bit that falls out
  always_comb begin
    step_data = work_reg;
    step_c    = 1'b0;
    if (left_reg) begin
      {step_c, step_data} = {work_reg, 1'b0};
    end else begin
      {step_data, step_c} = {work_reg[WIDTH-1], work_reg};
    end
  end

  assign done   = (cnt_reg == ONE_SH);
  assign result = step_data;
  assign carry  = step_c & ~zero_c_reg;

  // Load the job on start, then step once per cycle until the counter empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg   <= '0;
      cnt_reg    <= '0;
      left_reg   <= 1'b0;
      zero_c_reg <= 1'b0;
    end else if (start) begin
      work_reg   <= data;
      cnt_reg    <= (amount > WIDTH_SH) ? WIDTH_SH : amount;
      left_reg   <= left;
      zero_c_reg <= left && (amount > WIDTH_SH);
    end else if (cnt_reg != '0) begin
      work_reg <= step_data;
      cnt_reg  <= cnt_reg - ONE_SH;
    end
  end

endmodule

// File: rtl/alu_two_op_seq.sv
// alu_two_op_seq: handshaked two-operand execute unit owning the CCR {C,N,Z}.
// Non-shift ops complete in one cycle. Shifts go through an iterative shifter
// (min(shamt,WIDTH)+1 cycles) unless ALU_BARREL_SHIFT_EN is defined, in which
// case they are computed combinationally with one-cycle latency.
module alu_two_op_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            rst,
  alu_two_op_seq_if.slave bus
);

  logic             in_ready_int;
  logic             accept;
  logic             is_shift;
  logic             shamt_zero;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] imm_data;
  logic             imm_c;
  logic             imm_upd;
  logic             imm_ill;

  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             load_c;
  logic             load_upd;
  logic             load_ill;
  logic [2:0]       flags_next;

  logic             out_valid_reg;
  logic             out_illegal_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [2:0]       ccr_reg;

  assign accept     = bus.in_valid && in_ready_int;
  assign is_shift   = (bus.in_op == OP_SHL) || (bus.in_op == OP_SHR);
  assign shamt_zero = (bus.in_shamt == '0);

  // Single-cycle result and flag-update intent for the presented opcode
  always_comb begin
    ext      = '0;
    imm_data = '0;
    imm_c    = 1'b0;
    imm_upd  = 1'b1;
    imm_ill  = 1'b0;
    case (bus.in_op)
      OP_MOV: begin
        imm_data = bus.in_rs;
        imm_upd  = 1'b0;
      end
      OP_ADD: begin
        ext      = {1'b0, bus.in_rs} + {1'b0, bus.in_rd};
        imm_data = ext[WIDTH-1:0];
        imm_c    = ext[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of the difference is the unsigned borrow
        ext      = {1'b0, bus.in_rs} - {1'b0, bus.in_rd};
        imm_data = ext[WIDTH-1:0];
        imm_c    = ext[WIDTH];
      end
      OP_AND: imm_data = bus.in_rs & bus.in_rd;
      OP_OR:  imm_data = bus.in_rs | bus.in_rd;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SHL: begin
        // The bit above the word catches the last bit shifted out; amounts
        // beyond WIDTH push everything past it, giving 0 with carry 0
        ext      = {1'b0, bus.in_rs} << bus.in_shamt;
        imm_data = ext[WIDTH-1:0];
        imm_c    = ext[WIDTH];
      end
      OP_SHR: begin
        // The guard bit below the word catches the last bit shifted out;
        // large amounts fill everything, guard included, with the sign
        ext      = $signed({bus.in_rs, 1'b0}) >>> bus.in_shamt;
        imm_data = ext[WIDTH:1];
        imm_c    = ext[0];
      end
`else
      // Only reached for shamt==0 here; non-zero amounts use the shifter
      OP_SHL: imm_data = bus.in_rs;
      OP_SHR: imm_data = bus.in_rs;
`endif
      default: begin
        imm_upd = 1'b0;
        imm_ill = 1'b1;
      end
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN

  assign in_ready_int = (!out_valid_reg || bus.out_ready) && !rst;
  assign load         = accept;
  assign load_data    = imm_data;
  assign load_c       = imm_c;
  assign load_upd     = imm_upd;
  assign load_ill     = imm_ill;

`else

  alu_state_t       state_reg;
  alu_state_t       state_next;
  logic             sh_start;
  logic             sh_done;
  logic [WIDTH-1:0] sh_result;
  logic             sh_carry;

  assign sh_start = accept && is_shift && !shamt_zero;

  alu_shifter_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .start  (sh_start),
    .left   (bus.in_op == OP_SHL),
    .data   (bus.in_rs),
    .amount (bus.in_shamt),
    .done   (sh_done),
    .result (sh_result),
    .carry  (sh_carry)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: enter SHIFT on a non-trivial shift, leave when the shifter finishes
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (sh_start) state_next = ST_SHIFT;
      ST_SHIFT: if (sh_done)  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and the output slot is free or draining
  always_comb begin
    in_ready_int = (state_reg == ST_IDLE) && (!out_valid_reg || bus.out_ready) && !rst;
  end

  // Result source: shifter completion or a single-cycle op at accept
  always_comb begin
    load      = sh_done || (accept && !sh_start);
    load_data = imm_data;
    load_c    = imm_c;
    load_upd  = imm_upd;
    load_ill  = imm_ill;
    if (sh_done) begin
      load_data = sh_result;
      load_c    = sh_carry;
      load_upd  = 1'b1;
      load_ill  = 1'b0;
    end
  end

`endif

  always_comb begin
    flags_next        = '0;
    flags_next[CCR_C] = load_c;
    flags_next[CCR_N] = load_data[WIDTH-1];
    flags_next[CCR_Z] = (load_data == '0);
  end

  // Output register: load a new result, else drop valid once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_illegal_reg <= 1'b0;
    end else if (load) begin
      out_valid_reg   <= 1'b1;
      out_data_reg    <= load_data;
      out_illegal_reg <= load_ill;
    end else if (bus.out_ready) begin
      out_valid_reg   <= 1'b0;
    end
  end

  // CCR: a context restore overrides the flags of a result landing on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr_reg <= '0;
    end else if (bus.ccr_load) begin
      ccr_reg <= bus.ccr_in;
    end else if (load && load_upd) begin
      ccr_reg <= flags_next;
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_data    = out_data_reg;
  assign bus.out_illegal = out_illegal_reg;
  assign bus.ccr         = ccr_reg;

endmodule

// File: doc/alu_two_op_seq.md
# alu_two_op_seq

Parametrised, handshaked two-operand execute unit; successor to the combinational per-operation units (MOV/ADD/SUB/AND/OR/SHL/SHR). Sits in the execute stage between operand fetch and write-back. Owns the condition-code register (CCR) instead of receiving previous flags. Single-cycle ops issue back-to-back; shifts use an iterative shifter.

## Interface
Parameters:
- WIDTH, 16, operand/result width (≥4).
- SHAMT_W, $clog2(WIDTH)+1, width of shift-amount operand.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts operation this cycle.
- in_op  in  3  opcode (alu_pkg::alu_op_t).
- in_rs  in  WIDTH  source operand.
- in_rd  in  WIDTH  second operand.
- in_shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_data  out  WIDTH  result.
- out_illegal  out  1  result came from an undefined opcode.
- ccr  out  3  flags {C,N,Z}: bit2 carry, bit1 negative, bit0 zero.
- ccr_load  in  1  overwrite CCR (context restore).
- ccr_in  in  3  value for ccr_load.

## Operation
- Opcodes: 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SHL, 6 SHR (arithmetic), 7 illegal.
- Accept when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
- MOV: out=rs; CCR unchanged.
- ADD: {C,out}=rs+rd in WIDTH+1 bits. SUB: {C,out}=rs−rd in WIDTH+1 bits; C=1 iff rs<rd unsigned (borrow).
- AND/OR: C=0.
- SHL: logical shift by in_shamt; C=last bit shifted out, or 0 if shamt==0.
- SHR: arithmetic shift by in_shamt; C=last bit shifted out, or 0 if shamt==0.
- Shift amounts ≥WIDTH saturate. SHL gives 0 and C=0 if shamt>WIDTH, C=rs[0] if shamt==WIDTH. SHR gives all-sign-bits and C=rs[WIDTH-1].
- For all non-MOV legal ops: Z=(out==0), N=out[WIDTH-1].
- Illegal opcode: out=0, out_illegal=1, CCR unchanged.
- CCR updates in the same edge out_valid is set. If ccr_load fires on that edge, ccr_load wins.
- FSM:
  - IDLE: accepting a non-shift op, or a shift with shamt==0, loads the output register → IDLE. Accepting a shift with shamt>0 → SHIFT.
  - SHIFT: shift working register 1 bit/cycle and decrement the counter. When the counter reaches 0, load the output → IDLE.
- Output register holds value while out_valid && !out_ready. Cleared (out_valid=0) on out_ready unless a new result loads that edge.

## Timing
- Reset values: out_valid=0, out_data=0, out_illegal=0, ccr=0, state=IDLE, in_ready=0 while rst high.
- Latency: 1 cycle for non-shift ops; throughput 1/cycle when out_ready held high.
- Shift latency: min(shamt,WIDTH)+1 cycles from accept to out_valid. in_ready=0 throughout SHIFT.
- Reset mid-shift aborts: no result emitted, CCR=0.
- ccr_load is honoured in any state, including during SHIFT.

## Configuration
- ALU_BARREL_SHIFT_EN defined: SHL/SHR computed combinationally. Latency 1, same as other ops. SHIFT state and counter not built.
- ALU_BARREL_SHIFT_EN undefined: iterative shifter as above.
- Results and flags are identical in both builds; only timing differs.

## Structure
- alu_pkg: alu_op_t enum, flag index constants CCR_C=2, CCR_N=1, CCR_Z=0, state enum.
- Sub-module alu_shifter_iter: working register, counter, carry capture, done pulse. Replaced by combinational logic under ALU_BARREL_SHIFT_EN.

## Test plan
- Reset → all outputs 0. ADD 0xFFFF+0x0001 → out 0x0000, ccr=3'b101, 1 cycle later.
- SUB 0x0003−0x0005 → out 0xFFFE, ccr=3'b110. Then MOV 0x1234 → out 0x1234, ccr stays 3'b110.
- SHR 0x8001 by 3 → out 0xF000, C=0, N=1. Out_valid 4 cycles after accept (iterative) or 1 cycle (barrel). SHL 0x0001 by 16 → out 0, C=1, Z=1.
- Back-to-back ADD/AND/OR with out_ready=1 → one result per cycle. Drop out_ready for 3 cycles → out_data stable, in_ready=0.
- ccr_load=3'b010 on the same edge as the ADD 1+1 result → ccr=3'b010. Opcode 7 → out_illegal=1, ccr unchanged.
- Assert rst in the 2nd cycle of SHL by 10 → no out_valid, ccr=0. First op after release completes normally.
